fetch_queue: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Accepts each PC value, issues an in-order read request to instruction memory, and reserves a queue slot tagged with that PC. Holds returned instruction words and hands {pc, instr} pairs to decode over a valid/ready interface. A flush input discards queued and in-flight fetches on a redirect (branch/jump load of the PC).

---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - handshake bundle between PC, instruction memory, decode and the fetch queue
//
// Groups every non-clock signal of the fetch queue.
//   pc_in/pc_valid/pc_ready             : fetch address from the program counter
//   mem_req_valid/mem_req_addr/ready    : in-order read request to instruction memory
//   mem_rsp_valid/mem_rsp_data          : returned instruction words, request order
//   flush                               : redirect, discards queued and in-flight fetches
//   out_valid/out_pc/out_instr/ready    : {pc, instr} pairs to decode
//   rsp_err                             : sticky, response arrived with nothing outstanding
// Modport slave is the fetch queue itself; master is its environment.
interface fetch_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              flush;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic              out_ready;
    logic              rsp_err;

    modport slave (
        input  pc_in, pc_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, out_ready,
        output pc_ready, mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, rsp_err
    );

    modport master (
        output pc_in, pc_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, out_ready,
        input  pc_ready, mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, rsp_err
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with flush and stale-response dropping
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_queue_if.slave (PC input, memory request/response, flush, decode output, rsp_err)
//
// Each accepted PC reserves a slot and issues one memory read. Responses come back in
// request order and fill slots in allocation order. A flush empties the queue at once;
// responses still owed by memory for the discarded fetches are counted in drop_cnt and
// thrown away as they arrive, and they keep occupying capacity until they do.
module fetch_queue #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] slot_pc    [DEPTH];
    logic [DATA_W-1:0] slot_instr [DEPTH];
    logic [DEPTH-1:0]  filled;

    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  pending;
    logic [CNT_W-1:0]  drop_cnt;
    logic              rsp_err_q;

    logic [CNT_W:0]    used;
    logic [CNT_W:0]    stale_total;
    logic [CNT_W-1:0]  flush_drop;
    logic              can_issue;
    logic              issue;
    logic              fill;
    logic              pop;
    logic              drop_dec;
    logic              spurious;
    logic              rsp_hits_stale;

    // Stale responses still owed by memory count against capacity so that a burst
    // of new fetches after a flush can never outrun the slots it will need.
    assign used      = {1'b0, occupancy} + {1'b0, drop_cnt};
    assign can_issue = rst_n && !bus.flush && (used < (CNT_W+1)'(DEPTH));

    assign bus.mem_req_valid = bus.pc_valid && can_issue;
    assign bus.mem_req_addr  = bus.pc_in;
    assign bus.pc_ready      = bus.mem_req_ready && can_issue;
    assign issue             = bus.pc_valid && bus.pc_ready;

    assign bus.out_valid = !bus.flush && filled[rd_ptr] && (occupancy != '0);
    assign bus.out_pc    = slot_pc[rd_ptr];
    assign bus.out_instr = slot_instr[rd_ptr];
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.rsp_err   = rsp_err_q;

    // A response is consumed first by the stale count, then by the oldest pending slot.
    // With neither present it has no owner.
    assign stale_total    = {1'b0, drop_cnt} + {1'b0, pending};
    assign rsp_hits_stale = bus.mem_rsp_valid && (stale_total != '0);
    assign spurious       = bus.mem_rsp_valid && (stale_total == '0);
    assign drop_dec       = bus.mem_rsp_valid && (drop_cnt != '0) && !bus.flush;
    assign fill           = bus.mem_rsp_valid && (drop_cnt == '0) && (pending != '0) && !bus.flush;

    // On flush every pending fetch becomes stale; a response in the flush cycle retires one.
    assign flush_drop = stale_total[CNT_W-1:0] - {{(CNT_W-1){1'b0}}, rsp_hits_stale};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pending   <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (spurious) begin
                rsp_err_q <= 1'b1;
            end
            if (bus.flush) begin
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
                pending   <= '0;
                filled    <= '0;
                drop_cnt  <= flush_drop;
            end else begin
                // issue/fill/pop always target distinct slots: alloc_ptr meets fill_ptr
                // only when every slot is pending (queue full, no issue), and a pop
                // needs a filled head while a fill needs an unfilled slot.
                if (issue) begin
                    filled[alloc_ptr] <= 1'b0;
                    alloc_ptr         <= alloc_ptr + PTR_W'(1);
                end
                if (fill) begin
                    filled[fill_ptr] <= 1'b1;
                    fill_ptr         <= fill_ptr + PTR_W'(1);
                end
                if (pop) begin
                    filled[rd_ptr] <= 1'b0;
                    rd_ptr         <= rd_ptr + PTR_W'(1);
                end
                occupancy <= occupancy + CNT_W'(issue) - CNT_W'(pop);
                pending   <= pending + CNT_W'(issue) - CNT_W'(fill);
                if (drop_dec) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Slot payload carries no reset; the filled bits and occupancy guard every read.
    always_ff @(posedge clk) begin
        if (issue) begin
            slot_pc[alloc_ptr] <= bus.pc_in;
        end
        if (fill) begin
            slot_instr[fill_ptr] <= bus.mem_rsp_data;
        end
    end

    a_stale_bound: assert property (@(posedge clk) disable iff (!rst_n)
        stale_total <= (CNT_W+1)'(DEPTH));

    a_no_refill: assert property (@(posedge clk) disable iff (!rst_n)
        fill |-> !filled[fill_ptr]);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus sources ----------------
    logic [7:0] pc_q[$];

    always @(posedge clk) begin
        #2;
        bus.pc_valid = (pc_q.size() > 0);
        bus.pc_in    = (pc_q.size() > 0) ? pc_q[0] : 8'h00;
    end

    typedef struct {
        logic [7:0] addr;
        int         due;
    } req_t;
    req_t mem_q[$];
    int   mem_lat   = 1;
    int   spur_req  = 0;
    int   spur_done = 0;

    // In-order memory: word for address A is {24'hC0DE00, A}.
    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            mem_q.delete();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end else if (spur_req != spur_done) begin
            spur_done         = spur_req;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hDEADBEEF;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {24'hC0DE00, mem_q[0].addr};
            void'(mem_q.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
        end
    end

    // ---------------- logs of DUT handshakes ----------------
    int         iss_cyc[$];
    logic [7:0] iss_pc[$];
    int         pop_cyc[$];
    logic [7:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;
    ent_t m_q[$];
    int   m_drop = 0;
    bit   m_err  = 1'b0;

    always @(negedge clk) begin
        int   occ;
        int   pend;
        int   stale;
        int   idx;
        bit   can;
        bit   e_mv;
        bit   e_pr;
        bit   e_ov;
        if (!rst_n) begin
            m_q.delete();
            m_drop = 0;
            m_err  = 1'b0;
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
            check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        end else begin
            occ  = m_q.size();
            pend = 0;
            foreach (m_q[i]) if (!m_q[i].filled) pend++;
            can  = !bus.flush && (occ + m_drop < DEPTH);
            e_mv = bus.pc_valid && can;
            e_pr = bus.mem_req_ready && can;
            e_ov = !bus.flush && (occ > 0) && m_q[0].filled;

            check("cyc_mem_req_valid", 64'(bus.mem_req_valid), 64'(e_mv));
            check("cyc_pc_ready", 64'(bus.pc_ready), 64'(e_pr));
            check("cyc_out_valid", 64'(bus.out_valid), 64'(e_ov));
            check("cyc_rsp_err", 64'(bus.rsp_err), 64'(m_err));
            if (e_mv) check("cyc_mem_req_addr", 64'(bus.mem_req_addr), 64'(bus.pc_in));
            if (e_ov) begin
                check("cyc_out_pc", 64'(bus.out_pc), 64'(m_q[0].pc));
                check("cyc_out_instr", 64'(bus.out_instr), 64'(m_q[0].instr));
            end

            if (bus.pc_valid && bus.pc_ready) begin
                iss_cyc.push_back(cyc);
                iss_pc.push_back(bus.pc_in);
                if (pc_q.size() > 0) void'(pc_q.pop_front());
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                mem_q.push_back('{addr: bus.mem_req_addr, due: cyc + mem_lat});
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_cyc.push_back(cyc);
                pop_pc.push_back(bus.out_pc);
                pop_ins.push_back(bus.out_instr);
            end

            if (bus.flush) begin
                stale = m_drop + pend;
                if (bus.mem_rsp_valid) begin
                    if (stale > 0) stale--;
                    else m_err = 1'b1;
                end
                m_drop = stale;
                m_q.delete();
            end else begin
                if (e_ov && bus.out_ready) void'(m_q.pop_front());
                if (bus.mem_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        idx = -1;
                        foreach (m_q[i]) if (idx < 0 && !m_q[i].filled) idx = i;
                        if (idx >= 0) begin
                            m_q[idx].instr  = bus.mem_rsp_data;
                            m_q[idx].filled = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                if (bus.pc_valid && e_pr) m_q.push_back('{pc: bus.pc_in, instr: 32'h0, filled: 1'b0});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_logs();
        iss_cyc.delete();
        iss_pc.delete();
        pop_cyc.delete();
        pop_pc.delete();
        pop_ins.delete();
    endtask

    task automatic wait_iss(input int n, input string name);
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (iss_pc.size() < n && i < 200);
        #1;
        check(name, 64'(iss_pc.size()), 64'(n));
    endtask

    task automatic wait_pops(input int n, input string name);
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (pop_pc.size() < n && i < 200);
        #1;
        check(name, 64'(pop_pc.size()), 64'(n));
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] exp_pc[6];
        int         t_b;

        bus.mem_req_ready = 1'b1;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        rst_n             = 1'b0;

        // reset: a valid PC during reset must not produce a request
        pc_q.push_back(8'h33);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        pc_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_reset_rsp_err", 64'(bus.rsp_err), 64'd0);

        // streaming, latency 1
        @(posedge clk); #1;
        clear_logs();
        bus.out_ready = 1'b1;
        mem_lat       = 1;
        exp_pc        = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        for (int i = 0; i < 4; i++) pc_q.push_back(exp_pc[i]);
        wait_pops(4, "t1_pop_count");
        for (int i = 0; i < 4; i++) begin
            check("t1_pop_pc", 64'(pop_pc[i]), 64'(exp_pc[i]));
            check("t1_pop_instr", 64'(pop_ins[i]), 64'({24'hC0DE00, exp_pc[i]}));
        end
        check("t1_instr0_literal", 64'(pop_ins[0]), 64'h00000000C0DE0000);
        check("t1_instr3_literal", 64'(pop_ins[3]), 64'h00000000C0DE000C);
        check("t1_first_latency", 64'(pop_cyc[0] - iss_cyc[0]), 64'd2);
        check("t1_issue_b2b", 64'(iss_cyc[3] - iss_cyc[0]), 64'd3);
        check("t1_pop_b2b", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // backpressure: 6 PCs, decode stalled
        @(posedge clk); #1;
        clear_logs();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pc_q.push_back(exp_pc[i]);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_accepted", 64'(iss_pc.size()), 64'd4);
        check("t2_pc_ready_full", 64'(bus.pc_ready), 64'd0);
        check("t2_mem_req_valid_full", 64'(bus.mem_req_valid), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_pops(6, "t2_pop_count");
        for (int i = 0; i < 6; i++) check("t2_pop_pc", 64'(pop_pc[i]), 64'(exp_pc[i]));
        check("t2_fifth_after_pop", 64'(iss_cyc[4] - pop_cyc[0]), 64'd1);

        // flush with two fetches in flight
        @(posedge clk); #1;
        clear_logs();
        mem_lat = 4;
        pc_q.push_back(8'h10);
        pc_q.push_back(8'h14);
        wait_iss(2, "t3_issue_count");
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        pc_q.push_back(8'h40);
        wait_pops(1, "t3_pop_count");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t3_only_one_pop", 64'(pop_pc.size()), 64'd1);
        check("t3_pop_pc", 64'(pop_pc[0]), 64'h40);
        check("t3_pop_instr", 64'(pop_ins[0]), 64'h00000000C0DE0040);
        check("t3_drop_zero", 64'(dut.drop_cnt), 64'd0);
        check("t3_rsp_err", 64'(bus.rsp_err), 64'd0);

        // flush coincident with a response and a would-be pop
        @(posedge clk); #1;
        clear_logs();
        bus.out_ready = 1'b0;
        mem_lat       = 3;
        pc_q.push_back(8'h20);
        pc_q.push_back(8'h24);
        pc_q.push_back(8'h28);
        wait_iss(3, "t4_issue_count");
        t_b = iss_cyc[0];
        @(posedge clk); #1;
        check("t4_flush_cycle", 64'(cyc), 64'(t_b + 4));
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4_flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("t4_drop_one", 64'(dut.drop_cnt), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_no_pops", 64'(pop_pc.size()), 64'd0);
        check("t4_drop_zero", 64'(dut.drop_cnt), 64'd0);
        check("t4_rsp_err", 64'(bus.rsp_err), 64'd0);

        // spurious response with the queue empty
        @(posedge clk); #1;
        clear_logs();
        mem_lat = 1;
        spur_req++;
        @(negedge clk);
        check("t5_spur_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("t5_rsp_err_set", 64'(bus.rsp_err), 64'd1);
        check("t5_out_valid_after", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        pc_q.push_back(8'h50);
        wait_pops(1, "t5_pop_count");
        check("t5_pop_pc", 64'(pop_pc[0]), 64'h50);
        check("t5_rsp_err_sticky", 64'(bus.rsp_err), 64'd1);

        // async reset mid-operation
        @(posedge clk); #1;
        clear_logs();
        bus.out_ready = 1'b0;
        mem_lat       = 3;
        pc_q.push_back(8'h60);
        pc_q.push_back(8'h64);
        pc_q.push_back(8'h68);
        pc_q.push_back(8'h6C);
        wait_iss(3, "t6_issue_count");
        bus.mem_req_ready = 1'b0;
        @(posedge clk); #4;
        check("t6_pre_out_valid", 64'(bus.out_valid), 64'd1);
        check("t6_pre_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_async_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        pc_q.delete();
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_out_valid_after", 64'(bus.out_valid), 64'd0);
        check("t6_drop_zero", 64'(dut.drop_cnt), 64'd0);
        check("t6_occupancy_zero", 64'(dut.occupancy), 64'd0);
        check("t6_rsp_err_cleared", 64'(bus.rsp_err), 64'd0);
        @(posedge clk); #1;
        clear_logs();
        mem_lat       = 1;
        bus.out_ready = 1'b1;
        pc_q.push_back(8'h70);
        wait_pops(1, "t6_recover_pop");
        check("t6_recover_pc", 64'(pop_pc[0]), 64'h70);
        check("t6_recover_instr", 64'(pop_ins[0]), 64'h00000000C0DE0070);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
